stream_demux_reg: RTL and testbench
===================================

Name: stream_demux_reg

Overview:
- Parametrised, registered successor to the combinational 1:32 demultiplexer.
- Routes one DATA_W-bit word per cycle from a valid/ready input stream to one of N_CH output channels, selected by `in_sel`.
- Each channel has a one-entry output register with its own valid/ready handshake, so channels stall independently.
- Used between the CPU datapath and multi-destination peripherals and register-file write fan-out, where destinations can back-pressure.

Parameters:
- DATA_W, 32, width of the data word.
- N_CH, 32, number of output channels (2..64).
- SEL_W, 5, width of `in_sel`; must satisfy 2^SEL_W >= N_CH.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  N_CH  per-channel output register holds data.
- out_ready  input  N_CH  per-channel consumer accepts.
- out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- err_sel  output  1  sticky flag: a word with `in_sel` >= N_CH was dropped.
- err_clr  input  1  synchronous clear of `err_sel`.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Clock and reset (already decided): one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all `out_valid` = 0, all `out_data` = 0, `err_sel` = 0, `drop_cnt` = 0.
  - Reset asserted mid-transfer discards all held words immediately, with no output glitch beyond the clear.
- Handshake:
  - Input transfer occurs when `in_valid` & `in_ready`.
  - Output transfer on channel k occurs when `out_valid[k]` & `out_ready[k]`.
  - Once `out_valid[k]` is 1, `out_data[k]` is stable until it transfers.
- in_ready (combinational, no dependency on `in_valid`):
  - If `in_sel` < N_CH: `in_ready` = ~`out_valid[in_sel]` | `out_ready[in_sel]`.
  - If `in_sel` >= N_CH: `in_ready` = 1; the word is consumed and dropped.
- Latency:
  - A word accepted in cycle t appears with `out_valid[sel]` = 1 in cycle t+1.
  - Throughput is 1 word/cycle per channel when the consumer holds ready high.
- Per-channel register update, each posedge, in priority order:
  - Input transfer to k: load `in_data`, set `out_valid[k]` = 1. This covers simultaneous drain and refill: the new word replaces the old and valid stays 1.
  - Else output transfer on k: clear `out_valid[k]`; `out_data[k]` holds its last value.
  - Else: hold.
- Only the selected channel changes on an input transfer; all other channels are unaffected.
- Invalid select: an input transfer with `in_sel` >= N_CH does not touch any channel.
  - Sets `err_sel` = 1.
  - Increments `drop_cnt`, which saturates at 2^CNT_W-1.
- err_clr:
  - Clears `err_sel` next cycle.
  - If a new invalid-select transfer occurs in the same cycle, set wins and `err_sel` stays 1.
  - `err_clr` does not affect `drop_cnt`.
- No internal state machine beyond the per-channel valid bits; the per-channel states are EMPTY/FULL with the transitions above.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined:
  - Adds input port `in_bcast` (1 bit).
  - With `in_bcast` = 1, `in_sel` is ignored.
  - `in_ready` = AND over all k of (~`out_valid[k]` | `out_ready[k]`).
  - On transfer, all N_CH registers load `in_data` and set valid.
  - Broadcast never flags `err_sel`.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset, then `in_valid`=1, `in_sel`=5, `in_data`=0xDEADBEEF, all `out_ready`=0 -> next cycle `out_valid`=0x00000020 and `out_data[5]`=0xDEADBEEF; a second word to ch5 sees `in_ready`=0.
- ch5 full, `out_ready[5]`=1, new word 0x12345678 to ch5 in the same cycle -> `in_ready`=1; next cycle `out_valid[5]`=1 and `out_data[5]`=0x12345678.
- Streaming ch0..31 with sel incrementing each cycle, all `out_ready`=1 -> 32 words in 32 cycles, each seen exactly once on the correct channel.
- N_CH=20, `in_sel`=25 with `in_valid` held for 300 cycles -> `in_ready`=1 throughout, no `out_valid` bit set, `err_sel`=1, `drop_cnt`=255; `err_clr` pulse -> `err_sel`=0, `drop_cnt`=255.
- Assert `rst_n`=0 asynchronously while ch3 and ch7 are full -> `out_valid`=0 immediately, without waiting for a clock edge.
- DEMUX_BCAST_EN defined, `in_bcast`=1, ch2 full with `out_ready[2]`=0 -> `in_ready`=0; raise `out_ready[2]` -> transfer; next cycle all `out_valid`=all-ones with identical `out_data`.

Source files
------------

// File: rtl/stream_demux_reg.sv
// Registered 1:N_CH valid/ready stream demultiplexer.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_sel input stream;
//   out_valid/out_ready/out_data per-channel output registers;
//   err_sel sticky bad-select flag (cleared by err_clr);
//   drop_cnt saturating count of dropped words.
// Optional macro DEMUX_BCAST_EN adds in_bcast (load all channels).
module stream_demux_reg #(
  parameter int DATA_W = 32,
  parameter int N_CH   = 32,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                   in_bcast,
`endif
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   err_sel,
  input  logic                   err_clr,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [SEL_W:0] NCH =
    (SEL_W+1)'(N_CH);

  logic [N_CH-1:0]             valid_q;
  logic [N_CH-1:0]             valid_d;
  logic [N_CH-1:0][DATA_W-1:0] data_q;
  logic [N_CH-1:0][DATA_W-1:0] data_d;
  logic                        err_q;
  logic                        err_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] room;
  logic [N_CH-1:0] load;
  logic            sel_ok;
  logic            bcast;
  logic            in_xfer;
  logic            drop;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // A channel can take a word if empty
  // or draining this same cycle.
  assign room   = ~valid_q | out_ready;
  assign sel_ok = ({1'b0, in_sel} < NCH);

  always_comb begin
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &room;
    end else if (sel_ok) begin
      in_ready = |(hit & room);
    end
  end

  assign in_xfer = in_valid & in_ready;
  assign drop    = in_xfer & ~bcast & ~sel_ok;

  always_comb begin
    load = '0;
    if (in_xfer) begin
      load = bcast ? '1 : hit;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < N_CH; k++) begin
      if (load[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (drop) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign err_sel   = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_demux_reg.sv
// Directed self-checking bench for stream_demux_reg.
// Instance a: 32 channels; instance b: 20 channels for bad selects.
module tb_stream_demux_reg;

  logic        clk;
  logic        rst_n;

  logic        a_iv;
  logic        a_ir;
  logic [31:0] a_id;
  logic [4:0]  a_is;
  logic        a_bc;
  logic [31:0] a_ov;
  logic [31:0] a_or;
  logic [1023:0] a_od;
  logic        a_err;
  logic        a_clr;
  logic [7:0]  a_cnt;

  logic        b_iv;
  logic        b_ir;
  logic [31:0] b_id;
  logic [4:0]  b_is;
  logic        b_bc;
  logic [19:0] b_ov;
  logic [19:0] b_or;
  logic [639:0] b_od;
  logic        b_err;
  logic        b_clr;
  logic [7:0]  b_cnt;

  int vecs;
  int errs;

  stream_demux_reg u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_iv),
    .in_ready (a_ir),
    .in_data  (a_id),
    .in_sel   (a_is),
`ifdef DEMUX_BCAST_EN
    .in_bcast (a_bc),
`endif
    .out_valid(a_ov),
    .out_ready(a_or),
    .out_data (a_od),
    .err_sel  (a_err),
    .err_clr  (a_clr),
    .drop_cnt (a_cnt)
  );

  stream_demux_reg #(.N_CH(20)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_iv),
    .in_ready (b_ir),
    .in_data  (b_id),
    .in_sel   (b_is),
`ifdef DEMUX_BCAST_EN
    .in_bcast (b_bc),
`endif
    .out_valid(b_ov),
    .out_ready(b_or),
    .out_data (b_od),
    .err_sel  (b_err),
    .err_clr  (b_clr),
    .drop_cnt (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk("rst a_ov", 64'(a_ov), 64'h0);
    chk("rst a_od", 64'(|a_od), 64'h0);
    chk("rst b_err", 64'(b_err), 64'h0);
    chk("rst b_cnt", 64'(b_cnt), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    a_or = '0;
    a_iv = 1'b1;
    a_is = 5'd5;
    a_id = 32'hDEADBEEF;
    #1;
    chk("single rdy", 64'(a_ir), 64'h1);
    tick();
    chk("single ov", 64'(a_ov), 64'h20);
    chk("single od", 64'(a_od[5*32 +: 32]),
        64'hDEADBEEF);
    a_id = 32'hCAFEF00D;
    #1;
    chk("full rdy", 64'(a_ir), 64'h0);
    tick();
    chk("stall od", 64'(a_od[5*32 +: 32]),
        64'hDEADBEEF);
    chk("stall ov", 64'(a_ov), 64'h20);
  endtask

  task automatic test_refill();
    a_or[5] = 1'b1;
    a_id = 32'h12345678;
    #1;
    chk("refill rdy", 64'(a_ir), 64'h1);
    tick();
    chk("refill ov", 64'(a_ov), 64'h20);
    chk("refill od", 64'(a_od[5*32 +: 32]),
        64'h12345678);
    a_iv = 1'b0;
    tick();
    chk("drain ov", 64'(a_ov), 64'h0);
    chk("drain od", 64'(a_od[5*32 +: 32]),
        64'h12345678);
  endtask

  task automatic test_back_to_back();
    logic [31:0] one;
    a_or = '1;
    a_iv = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_is = 5'(i);
      a_id = 32'hA0000000 + 32'(i);
      #1;
      chk("b2b rdy", 64'(a_ir), 64'h1);
      tick();
      one = 32'h1 << i;
      chk("b2b ov", 64'(a_ov), 64'(one));
      chk("b2b od", 64'(a_od[i*32 +: 32]),
          64'(32'hA0000000 + 32'(i)));
    end
    a_iv = 1'b0;
    tick();
    chk("b2b end", 64'(a_ov), 64'h0);
  endtask

  task automatic test_bad_sel();
    b_or = '0;
    b_iv = 1'b1;
    b_is = 5'd25;
    b_id = 32'h55AA55AA;
    for (int i = 0; i < 300; i++) begin
      #1;
      chk("bad rdy", 64'(b_ir), 64'h1);
      tick();
      chk("bad ov", 64'(b_ov), 64'h0);
      if (i == 0)
        chk("cnt one", 64'(b_cnt), 64'h1);
      if (i == 254)
        chk("cnt 255", 64'(b_cnt), 64'hFF);
    end
    chk("bad err", 64'(b_err), 64'h1);
    chk("bad cnt", 64'(b_cnt), 64'hFF);
    b_clr = 1'b1;
    tick();
    chk("setwins", 64'(b_err), 64'h1);
    b_iv = 1'b0;
    tick();
    b_clr = 1'b0;
    chk("clr err", 64'(b_err), 64'h0);
    chk("clr cnt", 64'(b_cnt), 64'hFF);
    b_iv = 1'b1;
    b_is = 5'd19;
    b_id = 32'h00C0FFEE;
    #1;
    chk("ch19 rdy", 64'(b_ir), 64'h1);
    tick();
    b_iv = 1'b0;
    chk("ch19 ov", 64'(b_ov), 64'h80000);
    chk("ch19 od", 64'(b_od[19*32 +: 32]),
        64'h00C0FFEE);
    chk("ch19 err", 64'(b_err), 64'h0);
    chk("ch19 cnt", 64'(b_cnt), 64'hFF);
  endtask

  task automatic test_async_reset();
    a_or = '0;
    a_iv = 1'b1;
    a_is = 5'd3;
    a_id = 32'h33333333;
    tick();
    a_is = 5'd7;
    a_id = 32'h77777777;
    tick();
    a_iv = 1'b0;
    chk("ar full", 64'(a_ov), 64'h88);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar ov", 64'(a_ov), 64'h0);
    chk("ar od", 64'(|a_od), 64'h0);
    chk("ar bcnt", 64'(b_cnt), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef DEMUX_BCAST_EN
  task automatic test_bcast();
    logic [31:0] w;
    logic        same;
    a_or = '0;
    a_iv = 1'b1;
    a_is = 5'd2;
    a_id = 32'h22222222;
    tick();
    a_bc = 1'b1;
    a_is = 5'd9;
    a_id = 32'hB0B0B0B0;
    #1;
    chk("bc stall", 64'(a_ir), 64'h0);
    a_or[2] = 1'b1;
    #1;
    chk("bc rdy", 64'(a_ir), 64'h1);
    tick();
    a_iv = 1'b0;
    a_bc = 1'b0;
    a_or = '0;
    chk("bc ov", 64'(a_ov), 64'hFFFFFFFF);
    same = 1'b1;
    for (int k = 0; k < 32; k++) begin
      w = a_od[k*32 +: 32];
      if (w !== 32'hB0B0B0B0) same = 1'b0;
    end
    chk("bc od", 64'(same), 64'h1);
    chk("bc err", 64'(a_err), 64'h0);
  endtask
`endif

  initial begin
    vecs  = 0;
    errs  = 0;
    a_iv  = 1'b0;
    a_id  = '0;
    a_is  = '0;
    a_bc  = 1'b0;
    a_or  = '0;
    a_clr = 1'b0;
    b_iv  = 1'b0;
    b_id  = '0;
    b_is  = '0;
    b_bc  = 1'b0;
    b_or  = '0;
    b_clr = 1'b0;
    test_reset();
    test_single();
    test_refill();
    test_back_to_back();
    test_bad_sel();
    test_async_reset();
`ifdef DEMUX_BCAST_EN
    test_bcast();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
